// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

   // Default register index width (8 architectural registers).
   localparam int REG_BITS_DEF = 3;

   // Stored destination field width; narrower indices are zero-extended.
   localparam int REG_W_MAX = 8;

   // Hazard modes selected by FWD_EN.
   localparam int MODE_STALL_ALL = 0;  // no forwarding: any RAW match stalls
   localparam int MODE_FWD       = 1;  // forwarding: only load-use in EX stalls

   // One tracked in-flight writer.
   typedef struct packed {
      logic                 valid;
      logic [REG_W_MAX-1:0] dst;
      logic                 is_load;
   } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one scoreboard entry against the ID-stage source registers and
// reports whether that entry forces a stall in the selected hazard mode.
module hazard_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_BITS  = REG_BITS_DEF,
   parameter int FWD_EN    = MODE_STALL_ALL,
   parameter int ZERO_HARD = 0,
   parameter int IDX       = 0
) (
   input  entry_t              ent,
   input  logic [REG_BITS-1:0] rs,
   input  logic                rs_use,
   input  logic [REG_BITS-1:0] rt,
   input  logic                rt_use,
   output logic                hazard
);

   logic [REG_W_MAX-1:0] rs_x;
   logic [REG_W_MAX-1:0] rt_x;
   logic                 match;

   // Zero-extend source indices to the stored destination width.
   always_comb begin
      rs_x = '0;
      rt_x = '0;
      rs_x[REG_BITS-1:0] = rs;
      rt_x[REG_BITS-1:0] = rt;
   end

   // RAW match on either used source; a hardwired r0 never matches.
   always_comb begin
      match = ent.valid && ((rs_use && (rs_x == ent.dst)) ||
                            (rt_use && (rt_x == ent.dst)));
      if ((ZERO_HARD != 0) && (ent.dst == '0)) begin
         match = 1'b0;
      end
   end

   // With forwarding only a load still sitting in EX cannot be bypassed.
   always_comb begin
      if (FWD_EN == MODE_FWD) begin
         hazard = match && ent.is_load && (IDX == 0);
      end else begin
         hazard = match;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall detector: shift scoreboard of in-flight register writes,
// zero-latency stall output, flush/freeze handling and a saturating
// counter of stalled advancing cycles.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_BITS     = REG_BITS_DEF,
   parameter int DEPTH        = 2,
   parameter int FWD_EN       = MODE_STALL_ALL,
   parameter int ZERO_HARD    = 0,
   parameter int FLUSH_STAGES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic                id_rs_use,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_rt_use,
   input  logic                id_wr_en,
   input  logic [REG_BITS-1:0] id_wr_reg,
   input  logic                id_is_load,
   input  logic                pipe_adv,
   input  logic                flush,
   input  logic                cnt_clr,
   output logic                stall,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [DEPTH-1:0]    stall_src
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   entry_t           ent [DEPTH];
   entry_t           ent_new;
   logic [DEPTH-1:0] hazard;

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_match
         hazard_match #(
            .REG_BITS  (REG_BITS),
            .FWD_EN    (FWD_EN),
            .ZERO_HARD (ZERO_HARD),
            .IDX       (g)
         ) u_match (
            .ent    (ent[g]),
            .rs     (id_rs),
            .rs_use (id_rs_use),
            .rt     (id_rt),
            .rt_use (id_rt_use),
            .hazard (hazard[g])
         );
      end
   endgenerate

   assign stall_src = hazard & {DEPTH{id_valid}};
   assign stall     = |stall_src;

   // Entry that ID pushes into EX; a stalled or flushed instruction is a bubble.
   always_comb begin
      ent_new         = '0;
      ent_new.valid   = id_valid && id_wr_en && !stall && !flush;
      ent_new.dst[REG_BITS-1:0] = id_wr_reg;
      ent_new.is_load = id_is_load;
   end

   // Shift on advance; flush then clears the youngest entries (shifted or not).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent[k] <= '0;
         end
      end else begin
         if (pipe_adv) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
               ent[k] <= ent[k-1];
            end
            ent[0] <= ent_new;
         end
         if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (k < FLUSH_STAGES) begin
                  ent[k].valid <= 1'b0;
               end
            end
         end
      end
   end

   // Count stalled cycles that actually advance; clear wins, no wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (stall && pipe_adv && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations driven with shared inputs,
// a directed vector table, hand sequences and randomized cycles checked
// against a queue-based model of the in-flight writers.
module tb_hazard_scoreboard;

   localparam int DA = 2;
   localparam int DB = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_valid, id_rs_use, id_rt_use, id_wr_en, id_is_load;
   logic [2:0] id_rs, id_rt, id_wr_reg;
   logic pipe_adv, flush, cnt_clr;

   logic          stall_a, stall_b;
   logic [15:0]   cnt_a;
   logic [2:0]    cnt_b;
   logic [DA-1:0] src_a;
   logic [DB-1:0] src_b;

   int checks = 0;
   int failures = 0;

   // Clock
   always #5 clk = ~clk;

   // Config A: no forwarding, r0 ordinary, wide counter.
   hazard_scoreboard #(
      .REG_BITS(3), .DEPTH(DA), .FWD_EN(0), .ZERO_HARD(0), .FLUSH_STAGES(1), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
      .id_rt(id_rt), .id_rt_use(id_rt_use), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
      .id_is_load(id_is_load), .pipe_adv(pipe_adv), .flush(flush), .cnt_clr(cnt_clr),
      .stall(stall_a), .stall_cnt(cnt_a), .stall_src(src_a)
   );

   // Config B: forwarding, hardwired r0, 3-bit counter, deeper, 2-stage flush.
   hazard_scoreboard #(
      .REG_BITS(3), .DEPTH(DB), .FWD_EN(1), .ZERO_HARD(1), .FLUSH_STAGES(2), .CNT_W(3)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
      .id_rt(id_rt), .id_rt_use(id_rt_use), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
      .id_is_load(id_is_load), .pipe_adv(pipe_adv), .flush(flush), .cnt_clr(cnt_clr),
      .stall(stall_b), .stall_cnt(cnt_b), .stall_src(src_b)
   );

   // ---------------- reference model ----------------
   typedef struct {
      bit v;
      int r;
      bit ld;
   } rec_t;
   typedef rec_t rec_q_t[$];

   rec_q_t qa, qb;
   int mcnt_a = 0;
   int mcnt_b = 0;
   bit m_init = 0;

   // Bitmask of in-flight writers the current ID instruction must wait for.
   function automatic int model_src(input rec_q_t q, input bit fwd, input bit zh);
      int s = 0;
      for (int k = 0; k < q.size(); k++) begin
         bit hit;
         hit = q[k].v && ((id_rs_use && int'(id_rs) == q[k].r) ||
                          (id_rt_use && int'(id_rt) == q[k].r));
         if (zh && q[k].r == 0) hit = 0;
         if (fwd && !(k == 0 && q[k].ld)) hit = 0;
         if (id_valid && hit) s = s | (1 << k);
      end
      return s;
   endfunction

   task automatic next_q(input rec_q_t qi, input int fl, input bit stl, output rec_q_t qo);
      rec_t n;
      qo = qi;
      if (!rst_n) begin
         for (int k = 0; k < qo.size(); k++) qo[k].v = 0;
      end else begin
         if (pipe_adv) begin
            n.v  = id_valid && id_wr_en && !stl && !flush;
            n.r  = int'(id_wr_reg);
            n.ld = id_is_load;
            void'(qo.pop_back());
            qo.push_front(n);
         end
         if (flush) begin
            for (int k = 0; k < fl && k < qo.size(); k++) qo[k].v = 0;
         end
      end
   endtask

   function automatic int next_cnt(input int c, input bit stl, input int cmax);
      if (!rst_n || cnt_clr) return 0;
      if (stl && pipe_adv && c < cmax) return c + 1;
      return c;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle: compare combinational outputs to the model, then clock.
   task automatic step();
      int sa, sb;
      rec_q_t na, nb;
      #1;
      sa = model_src(qa, 0, 0);
      sb = model_src(qb, 1, 1);
      if (m_init) begin
         check("m_stall_a", 32'(stall_a), 32'(sa != 0));
         check("m_src_a",   32'(src_a),   sa);
         check("m_cnt_a",   32'(cnt_a),   mcnt_a);
         check("m_stall_b", 32'(stall_b), 32'(sb != 0));
         check("m_src_b",   32'(src_b),   sb);
         check("m_cnt_b",   32'(cnt_b),   mcnt_b);
      end
      @(posedge clk);
      next_q(qa, 1, sa != 0, na);
      next_q(qb, 2, sb != 0, nb);
      qa = na;
      qb = nb;
      mcnt_a = next_cnt(mcnt_a, sa != 0, 65535);
      mcnt_b = next_cnt(mcnt_b, sb != 0, 7);
      if (!rst_n) m_init = 1;
      @(negedge clk);
   endtask

   // ---------------- driver ----------------
   task automatic set_in(input bit vld, input int rs, input bit rsu, input int rt, input bit rtu,
                         input bit we, input int wr, input bit ld, input bit adv,
                         input bit fl, input bit clr);
      id_valid   = vld;
      id_rs      = 3'(rs);
      id_rs_use  = rsu;
      id_rt      = 3'(rt);
      id_rt_use  = rtu;
      id_wr_en   = we;
      id_wr_reg  = 3'(wr);
      id_is_load = ld;
      pipe_adv   = adv;
      flush      = fl;
      cnt_clr    = clr;
   endtask

   // ---------------- directed table (config A) ----------------
   typedef struct {
      bit vld; int rs; bit rsu; int rt; bit rtu; bit we; int wr; bit ld;
      bit adv; bit fl; bit clr;
      bit e_stall; int e_src; int e_cnt;
   } vec_t;

   function automatic vec_t mk(input bit vld, input int rs, input bit rsu, input int rt,
                               input bit rtu, input bit we, input int wr, input bit ld,
                               input bit adv, input bit fl, input bit clr,
                               input bit es, input int esrc, input int ecnt);
      vec_t v;
      v.vld = vld; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu; v.we = we; v.wr = wr;
      v.ld = ld; v.adv = adv; v.fl = fl; v.clr = clr;
      v.e_stall = es; v.e_src = esrc; v.e_cnt = ecnt;
      return v;
   endfunction

   vec_t tab[19];

   initial begin
      for (int k = 0; k < DA; k++) qa.push_back('{v: 0, r: 0, ld: 0});
      for (int k = 0; k < DB; k++) qb.push_back('{v: 0, r: 0, ld: 0});

      //           vld rs rsu rt rtu we wr ld adv fl clr  stall src cnt
      tab[0]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0,   0, 0, 0);  // write r3
      tab[1]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0);  // read r3: EX match
      tab[2]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0,   1, 2, 1);  // oldest match
      tab[3]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 2);  // released
      tab[4]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0,   0, 0, 2);  // write r3
      tab[5]  = mk(1, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0,   0, 0, 2);  // rt=r3 unused
      tab[6]  = mk(1, 1, 1, 3, 1, 0, 0, 0, 1, 0, 0,   1, 2, 2);  // rt=r3 used
      tab[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 3);
      tab[8]  = mk(1, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0,   0, 0, 3);  // write r6
      tab[9]  = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 3);  // frozen
      tab[10] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 3);
      tab[11] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 3);
      tab[12] = mk(1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 3);  // resume
      tab[13] = mk(1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0,   1, 2, 4);
      tab[14] = mk(1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 5);
      tab[15] = mk(1, 0, 0, 0, 0, 1, 4, 0, 1, 1, 0,   0, 0, 5);  // write r4, flushed
      tab[16] = mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 5);  // read r4
      tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 5);  // clear counter
      tab[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0);

      // Reset
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      check("reset_stall_a", 32'(stall_a), 0);
      check("reset_src_a",   32'(src_a),   0);
      check("reset_cnt_a",   32'(cnt_a),   0);
      check("reset_cnt_b",   32'(cnt_b),   0);

      // Directed table
      for (int i = 0; i < 19; i++) begin
         set_in(tab[i].vld, tab[i].rs, tab[i].rsu, tab[i].rt, tab[i].rtu, tab[i].we,
                tab[i].wr, tab[i].ld, tab[i].adv, tab[i].fl, tab[i].clr);
         #1;
         check($sformatf("tab%0d_stall", i), 32'(stall_a), 32'(tab[i].e_stall));
         check($sformatf("tab%0d_src", i),   32'(src_a),   tab[i].e_src);
         check($sformatf("tab%0d_cnt", i),   32'(cnt_a),   tab[i].e_cnt);
         step();
      end

      // Config B: load-use stalls exactly once
      set_in(1, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0);
      step();
      set_in(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      #1 check("ld_use_stall", 32'(stall_b), 1);
      step();
      #1 check("ld_use_release", 32'(stall_b), 0);
      step();

      // Config B: ALU result is forwarded
      set_in(1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0);
      step();
      set_in(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0);
      #1 check("alu_fwd", 32'(stall_b), 0);
      step();

      // r0: hardwired in B, ordinary in A
      set_in(1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
      step();
      set_in(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      #1;
      check("zero_hard", 32'(stall_b), 0);
      check("zero_soft", 32'(stall_a), 1);
      step();

      // Config B counter saturates at 7 after 9 stalled cycles
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      step();
      for (int i = 0; i < 9; i++) begin
         set_in(1, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0);
         step();
         set_in(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
         step();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #1 check("cnt_sat", 32'(cnt_b), 7);
      step();

      // Reset with two valid entries and a nonzero count
      set_in(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      step();
      set_in(1, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0);
      step();
      set_in(1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      check("rst_stall_a", 32'(stall_a), 0);
      check("rst_cnt_a",   32'(cnt_a),   0);
      check("rst_cnt_b",   32'(cnt_b),   0);
      step();

      // Randomized cycles against the model
      for (int i = 0; i < 500; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0);
         rst_n = ($urandom_range(0, 60) != 0);
         step();
      end
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
